// File: rtl/pipe_pkg.sv
// Shared widths, FSM state and the ID/EX register layout for the pipeline slice.
// The struct below is the single source of truth for what ID/EX carries.
package pipe_pkg;

  localparam int DATA_W  = 16;
  localparam int REG_W   = 4;
  localparam int ALUOP_W = 4;

  typedef enum logic {
    RUN    = 1'b0,
    SWAP_B = 1'b1
  } state_t;

  typedef struct packed {
    logic [REG_W-1:0]   regRs;
    logic [REG_W-1:0]   regRt;
    logic               regWrite;
    logic               memRead;
    logic               memWrite;
    logic               swapOp;
    logic               swapPhase;
    logic [ALUOP_W-1:0] aluOp;
    logic [DATA_W-1:0]  readData1;
    logic [DATA_W-1:0]  readData2;
    logic [DATA_W-1:0]  imm;
  } id_ex_t;

  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs, ID/EX register outputs and the PC/IF-ID hold lines of one stage.
// master = whoever plays the ID stage and EX consumer; slave = id_ex_stage.
interface id_ex_stage_if
  import pipe_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int RW = REG_W,
  parameter int AW = ALUOP_W
);
  logic          IF_ID_Valid;
  logic [RW-1:0] IF_ID_RegisterRS;
  logic [RW-1:0] IF_ID_RegisterRT;
  logic          ID_RegWrite;
  logic          ID_MemRead;
  logic          ID_MemWrite;
  logic          ID_SwapOp;
  logic [AW-1:0] ID_ALUOp;
  logic [DW-1:0] ID_ReadData1;
  logic [DW-1:0] ID_ReadData2;
  logic [DW-1:0] ID_Imm;
  logic          Flush;

  logic [RW-1:0] ID_EX_RegisterRS;
  logic [RW-1:0] ID_EX_RegisterRT;
  logic          ID_EX_RegWrite;
  logic          ID_EX_MemRead;
  logic          ID_EX_MemWrite;
  logic          ID_EX_SwapOp;
  logic          ID_EX_SwapPhase;
  logic [AW-1:0] ID_EX_ALUOp;
  logic [DW-1:0] ID_EX_ReadData1;
  logic [DW-1:0] ID_EX_ReadData2;
  logic [DW-1:0] ID_EX_Imm;
  logic          PCWrite;
  logic          IF_ID_Write;

  modport master (
    output IF_ID_Valid, IF_ID_RegisterRS, IF_ID_RegisterRT,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_SwapOp, ID_ALUOp,
           ID_ReadData1, ID_ReadData2, ID_Imm, Flush,
    input  ID_EX_RegisterRS, ID_EX_RegisterRT, ID_EX_RegWrite, ID_EX_MemRead,
           ID_EX_MemWrite, ID_EX_SwapOp, ID_EX_SwapPhase, ID_EX_ALUOp,
           ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, PCWrite, IF_ID_Write
  );

  modport slave (
    input  IF_ID_Valid, IF_ID_RegisterRS, IF_ID_RegisterRT,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_SwapOp, ID_ALUOp,
           ID_ReadData1, ID_ReadData2, ID_Imm, Flush,
    output ID_EX_RegisterRS, ID_EX_RegisterRT, ID_EX_RegWrite, ID_EX_MemRead,
           ID_EX_MemWrite, ID_EX_SwapOp, ID_EX_SwapPhase, ID_EX_ALUOp,
           ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Imm, PCWrite, IF_ID_Write
  );
endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: the load now in ID/EX writes a register the instruction in ID reads.
// R0 is hardwired to zero, so a load targeting it never creates a dependency.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic             exMemRead,
  input  logic             exRegWrite,
  input  logic [REG_W-1:0] exRegRt,
  input  logic             idValid,
  input  logic [REG_W-1:0] idRegRs,
  input  logic [REG_W-1:0] idRegRt,
  output logic             loadUse
);

  assign loadUse = exMemRead && exRegWrite && idValid
                && (exRegRt != '0)
                && ((exRegRt == idRegRs) || (exRegRt == idRegRt));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, two-phase swap expansion and branch flush.
// PCWrite and IF_ID_Write are one combinational hold line presented twice.
module id_ex_stage
  import pipe_pkg::*;
(
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  state_t state, nextState;
  id_ex_t idEx, nextIdEx, idFields;
  logic   loadUse;
  logic   pcWrite;

  hazard_detect u_hazard (
    .exMemRead (idEx.memRead),
    .exRegWrite(idEx.regWrite),
    .exRegRt   (idEx.regRt),
    .idValid   (bus.IF_ID_Valid),
    .idRegRs   (bus.IF_ID_RegisterRS),
    .idRegRt   (bus.IF_ID_RegisterRT),
    .loadUse   (loadUse)
  );

  always_comb begin
    idFields = '{
      regRs:     bus.IF_ID_RegisterRS,
      regRt:     bus.IF_ID_RegisterRT,
      regWrite:  bus.ID_RegWrite,
      memRead:   bus.ID_MemRead,
      memWrite:  bus.ID_MemWrite,
      swapOp:    1'b0,
      swapPhase: 1'b0,
      aluOp:     bus.ID_ALUOp,
      readData1: bus.ID_ReadData1,
      readData2: bus.ID_ReadData2,
      imm:       bus.ID_Imm
    };
  end

  // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    nextState = state;
    nextIdEx  = ID_EX_BUBBLE;
    pcWrite   = 1'b1;
    if (rst) begin
      nextState = RUN;
      pcWrite   = 1'b0;
    end else if (bus.Flush) begin
      nextState = RUN;
    end else if (state == RUN && loadUse) begin
      pcWrite = 1'b0;
    end else if (state == RUN && bus.ID_SwapOp && bus.IF_ID_Valid) begin
      nextIdEx        = idFields;
      nextIdEx.swapOp = 1'b1;
      pcWrite         = 1'b0;
      nextState       = SWAP_B;
    end else if (state == SWAP_B) begin
      // IF/ID was held last cycle, so ID still presents the swap instruction.
      nextIdEx           = idFields;
      nextIdEx.swapOp    = 1'b1;
      nextIdEx.swapPhase = 1'b1;
      nextState          = RUN;
    end else if (bus.IF_ID_Valid) begin
      nextIdEx = idFields;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      idEx  <= ID_EX_BUBBLE;
    end else begin
      state <= nextState;
      idEx  <= nextIdEx;
    end
  end

  assign bus.ID_EX_RegisterRS = idEx.regRs;
  assign bus.ID_EX_RegisterRT = idEx.regRt;
  assign bus.ID_EX_RegWrite   = idEx.regWrite;
  assign bus.ID_EX_MemRead    = idEx.memRead;
  assign bus.ID_EX_MemWrite   = idEx.memWrite;
  assign bus.ID_EX_SwapOp     = idEx.swapOp;
  assign bus.ID_EX_SwapPhase  = idEx.swapPhase;
  assign bus.ID_EX_ALUOp      = idEx.aluOp;
  assign bus.ID_EX_ReadData1  = idEx.readData1;
  assign bus.ID_EX_ReadData2  = idEx.readData2;
  assign bus.ID_EX_Imm        = idEx.imm;
  assign bus.PCWrite          = pcWrite;
  assign bus.IF_ID_Write      = pcWrite;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed, table-driven bench for id_ex_stage: each vector drives ID for one cycle,
// checks the hold line before the edge and the ID/EX contents after it.
module tb_id_ex_stage;
  import pipe_pkg::*;

  typedef struct {
    logic   rst;
    logic   flush;
    logic   valid;
    id_ex_t in;     // swapOp carries ID_SwapOp; swapPhase is unused on input
    logic   expPc;
    id_ex_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   nApplied = 0;
  int   nFail    = 0;
  vec_t vecs[$];

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic id_ex_t fld(input logic [3:0] rs, rt, input logic rw, mr, mw, sw, ph,
                                 input logic [3:0] alu, input logic [15:0] d1, d2, im);
    fld = '{regRs: rs, regRt: rt, regWrite: rw, memRead: mr, memWrite: mw, swapOp: sw,
            swapPhase: ph, aluOp: alu, readData1: d1, readData2: d2, imm: im};
  endfunction

  function automatic vec_t mk(input logic r, f, v, input id_ex_t i, input logic p, input id_ex_t e);
    mk = '{rst: r, flush: f, valid: v, in: i, expPc: p, exp: e};
  endfunction

  task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
    nApplied++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst                  = v.rst;
    bus.Flush            = v.flush;
    bus.IF_ID_Valid      = v.valid;
    bus.IF_ID_RegisterRS = v.in.regRs;
    bus.IF_ID_RegisterRT = v.in.regRt;
    bus.ID_RegWrite      = v.in.regWrite;
    bus.ID_MemRead       = v.in.memRead;
    bus.ID_MemWrite      = v.in.memWrite;
    bus.ID_SwapOp        = v.in.swapOp;
    bus.ID_ALUOp         = v.in.aluOp;
    bus.ID_ReadData1     = v.in.readData1;
    bus.ID_ReadData2     = v.in.readData2;
    bus.ID_Imm           = v.in.imm;
  endtask

  task automatic apply(input string tag, input vec_t v);
    id_ex_t got;
    @(negedge clk);
    drive(v);
    #1;
    check({tag, ".hold"}, {78'd0, bus.PCWrite, bus.IF_ID_Write}, {78'd0, v.expPc, v.expPc});
    @(posedge clk);
    #1;
    got = '{regRs: bus.ID_EX_RegisterRS, regRt: bus.ID_EX_RegisterRT,
            regWrite: bus.ID_EX_RegWrite, memRead: bus.ID_EX_MemRead,
            memWrite: bus.ID_EX_MemWrite, swapOp: bus.ID_EX_SwapOp,
            swapPhase: bus.ID_EX_SwapPhase, aluOp: bus.ID_EX_ALUOp,
            readData1: bus.ID_EX_ReadData1, readData2: bus.ID_EX_ReadData2,
            imm: bus.ID_EX_Imm};
    check({tag, ".idex"}, 80'(got), 80'(v.exp));
  endtask

  initial begin
    id_ex_t junk, add1, lw3, addR3, lw0, addR0, lw9, swR9, swap25, addX, addY;
    junk   = fld(4'hF, 4'hE, 1, 1, 1, 1, 0, 4'hD, 16'hFFFF, 16'hEEEE, 16'hDDDD);
    add1   = fld(4'd1, 4'd2, 1, 0, 0, 0, 0, 4'd2, 16'h1111, 16'h2222, 16'h0005);
    lw3    = fld(4'd4, 4'd3, 1, 1, 0, 0, 0, 4'd1, 16'h0100, 16'h0300, 16'h0004);
    addR3  = fld(4'd3, 4'd6, 1, 0, 0, 0, 0, 4'd2, 16'hAAAA, 16'hBBBB, 16'h0000);
    lw0    = fld(4'd5, 4'd0, 1, 1, 0, 0, 0, 4'd1, 16'h0055, 16'h0000, 16'h0008);
    addR0  = fld(4'd0, 4'd7, 1, 0, 0, 0, 0, 4'd2, 16'h0000, 16'h0777, 16'h0000);
    lw9    = fld(4'd1, 4'd9, 1, 1, 0, 0, 0, 4'd1, 16'h1000, 16'h0999, 16'h0010);
    swR9   = fld(4'd2, 4'd9, 0, 0, 1, 0, 0, 4'd1, 16'h2000, 16'h9999, 16'h0002);
    swap25 = fld(4'd2, 4'd5, 1, 0, 0, 1, 0, 4'd3, 16'h2222, 16'h5555, 16'h0000);
    addX   = fld(4'd8, 4'd6, 1, 0, 0, 0, 0, 4'd2, 16'h1234, 16'h5678, 16'h0000);
    addY   = fld(4'd3, 4'd1, 1, 0, 0, 0, 0, 4'd4, 16'hCAFE, 16'hBEEF, 16'h0003);

    drive(mk(1, 1, 1, junk, 0, ID_EX_BUBBLE));

    // reset with every input nonzero, then a straight-through instruction
    vecs.push_back(mk(1, 1, 1, junk,  0, ID_EX_BUBBLE));
    vecs.push_back(mk(1, 1, 1, junk,  0, ID_EX_BUBBLE));
    vecs.push_back(mk(0, 0, 1, add1,  1, add1));
    // load-use via RS: one bubble, ADD follows with RS=3
    vecs.push_back(mk(0, 0, 1, lw3,   1, lw3));
    vecs.push_back(mk(0, 0, 1, addR3, 0, ID_EX_BUBBLE));
    vecs.push_back(mk(0, 0, 1, addR3, 1, addR3));
    // load into R0 never stalls
    vecs.push_back(mk(0, 0, 1, lw0,   1, lw0));
    vecs.push_back(mk(0, 0, 1, addR0, 1, addR0));
    // load-use via RT
    vecs.push_back(mk(0, 0, 1, lw9,   1, lw9));
    vecs.push_back(mk(0, 0, 1, swR9,  0, ID_EX_BUBBLE));
    vecs.push_back(mk(0, 0, 1, swR9,  1, swR9));
    // invalid slot gives a bubble regardless of field contents
    vecs.push_back(mk(0, 0, 0, junk,  1, ID_EX_BUBBLE));
    // swap R2,R5: two micro-ops, hold only during the first
    vecs.push_back(mk(0, 0, 1, swap25, 0, fld(4'd2, 4'd5, 1, 0, 0, 1, 0, 4'd3, 16'h2222, 16'h5555, 16'h0000)));
    vecs.push_back(mk(0, 0, 1, swap25, 1, fld(4'd2, 4'd5, 1, 0, 0, 1, 1, 4'd3, 16'h2222, 16'h5555, 16'h0000)));
    vecs.push_back(mk(0, 0, 1, addX,  1, addX));

    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("vec%0d", i), vecs[i]);

    // flush in SWAP_B: bubble, no phase-1 micro-op, back in RUN
    apply("flushSwap.p0", mk(0, 0, 1, swap25, 0, fld(4'd2, 4'd5, 1, 0, 0, 1, 0, 4'd3, 16'h2222, 16'h5555, 16'h0000)));
    apply("flushSwap.fl", mk(0, 1, 1, swap25, 1, ID_EX_BUBBLE));
    apply("flushSwap.run", mk(0, 0, 1, addY, 1, addY));

    // flush coinciding with a load-use hazard: no stall
    apply("flushLu.lw",   mk(0, 0, 1, lw3,   1, lw3));
    apply("flushLu.fl",   mk(0, 1, 1, addR3, 1, ID_EX_BUBBLE));
    apply("flushLu.next", mk(0, 0, 1, addR3, 1, addR3));

    // reset mid-swap: bubble, then no residual hold
    apply("rstSwap.p0",   mk(0, 0, 1, swap25, 0, fld(4'd2, 4'd5, 1, 0, 0, 1, 0, 4'd3, 16'h2222, 16'h5555, 16'h0000)));
    apply("rstSwap.rst",  mk(1, 0, 1, swap25, 0, ID_EX_BUBBLE));
    apply("rstSwap.run",  mk(0, 0, 1, addX,  1, addX));

    // reset mid-stall: bubble, then the dependent instruction passes immediately
    apply("rstLu.lw",     mk(0, 0, 1, lw3,   1, lw3));
    apply("rstLu.rst",    mk(1, 0, 1, addR3, 0, ID_EX_BUBBLE));
    apply("rstLu.run",    mk(0, 0, 1, addR3, 1, addR3));

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
    $finish;
  end

endmodule
